// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and default constants for the data-bus arbiter.
//   state_t  : sequencer states
//   access_t : class of a CPU access as seen by the address decoder
//   grant_t  : which requester owned the bus most recently
//   *_DEF    : default I/O region prefix and register addresses
package dbus_pkg;

  localparam logic [21:0] IO_PREFIX_DEF = 22'h3FFFFF;
  localparam logic [31:0] LED_ADDR_DEF  = 32'hFFFFFC60;
  localparam logic [31:0] SW_ADDR_DEF   = 32'hFFFFFC70;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_DONE,
    ST_LD_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACC_MEM,
    ACC_LED,
    ACC_SW,
    ACC_UNMAPPED
  } access_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_LD
  } grant_t;

endpackage

// File: rtl/dbus_addr_decode.sv
// dbus_addr_decode: combinational classifier for CPU bus addresses.
// Ports:
//   word_addr in  30  CPU byte address with bits [1:0] already dropped
//   access    out     ACC_MEM outside the I/O region, ACC_LED / ACC_SW for
//                     the two mapped registers, ACC_UNMAPPED otherwise
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter logic [21:0] IO_PREFIX = IO_PREFIX_DEF,
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [31:0] SW_ADDR   = SW_ADDR_DEF
) (
  input  logic [29:0] word_addr,
  output access_t     access
);

  // The I/O region is the top 1 KiB; registers are matched on the word
  // address so the byte offset within a word never matters.
  always_comb begin
    access = ACC_MEM;
    if (word_addr[29:8] == IO_PREFIX) begin
      if (word_addr == LED_ADDR[31:2]) begin
        access = ACC_LED;
      end else if (word_addr == SW_ADDR[31:2]) begin
        access = ACC_SW;
      end else begin
        access = ACC_UNMAPPED;
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: sequencer/arbiter for the data bus shared by the CPU
// load/store port and the UART program loader.
// Optional feature macro: UART_LOADER_EN (loader path, LD_DONE state and
// alternating arbitration). Without it the CPU is the only requester, the
// ld_* inputs are ignored and ld_ack is held low.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata            CPU access request (held until ready)
//   cpu_rdata, cpu_ready             load data and one-cycle completion pulse
//   ld_req/addr/wdata, ld_ack        loader word-write request and ack pulse
//   mem_en/we/addr/wdata, mem_rdata  data BRAM port (one-cycle read latency)
//   led_out, sw_in                   registered LEDs, switch inputs
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter logic [21:0] IO_PREFIX = IO_PREFIX_DEF,
  parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [31:0] SW_ADDR   = SW_ADDR_DEF,
  parameter int          MEM_AW    = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       led_out,
  input  logic [15:0]       sw_in
);

  state_t  state;
  state_t  next_state;
  access_t access;
  logic    grant_cpu;
  logic    grant_ld;
  logic    unused_byte_sel;

  // The byte offset of a CPU address is irrelevant on this word bus.
  assign unused_byte_sel = ^cpu_addr[1:0];

  dbus_addr_decode #(
    .IO_PREFIX(IO_PREFIX),
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_decode (
    .word_addr(cpu_addr[31:2]),
    .access   (access)
  );

`ifdef UART_LOADER_EN
  grant_t last_grant;

  // Remember who owned the bus last so a tie goes to the other side.
  // Reset value CPU hands the very first tie to the loader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_CPU;
    end else if (grant_ld) begin
      last_grant <= GRANT_LD;
    end else if (grant_cpu) begin
      last_grant <= GRANT_CPU;
    end
  end

  assign ld_ack = (state == ST_LD_DONE);
`else
  logic unused_ld;

  assign unused_ld = ^{ld_req, ld_addr, ld_wdata};
  assign ld_ack    = 1'b0;
`endif

  // Ready is a pure function of the state, so it is glitch-free, exactly
  // one cycle long and low out of reset.
  assign cpu_ready = (state == ST_DONE);

  // Grant, BRAM drive and next-state. Memory accesses drive the BRAM in the
  // acceptance cycle itself; I/O accesses only need the edge that follows.
  always_comb begin
    next_state = state;
    grant_cpu  = 1'b0;
    grant_ld   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
`ifdef UART_LOADER_EN
        if (cpu_req && ld_req) begin
          if (last_grant == GRANT_CPU) begin
            grant_ld = 1'b1;
          end else begin
            grant_cpu = 1'b1;
          end
        end else begin
          grant_cpu = cpu_req;
          grant_ld  = ld_req;
        end
        if (grant_ld) begin
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = ld_addr;
          mem_wdata  = ld_wdata;
          next_state = ST_LD_DONE;
        end
`else
        grant_cpu = cpu_req;
`endif
        if (grant_cpu) begin
          if (access == ACC_MEM) begin
            mem_en   = 1'b1;
            mem_we   = cpu_we;
            mem_addr = cpu_addr[MEM_AW+1:2];
            if (cpu_we) begin
              mem_wdata  = cpu_wdata;
              next_state = ST_DONE;
            end else begin
              next_state = ST_RD_WAIT;
            end
          end else begin
            next_state = ST_DONE;
          end
        end
      end
      ST_RD_WAIT: next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      ST_LD_DONE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // State register plus the data-path registers. cpu_rdata only changes
  // when a load completes, so it holds across stores and idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cpu_rdata <= '0;
      led_out   <= '0;
    end else begin
      state <= next_state;
      if (state == ST_RD_WAIT) begin
        cpu_rdata <= mem_rdata;
      end
      if (grant_cpu) begin
        case (access)
          ACC_LED: begin
            if (cpu_we) begin
              led_out <= cpu_wdata[15:0];
            end
          end
          ACC_SW: begin
            if (!cpu_we) begin
              cpu_rdata <= {16'h0, sw_in};
            end
          end
          ACC_UNMAPPED: begin
            if (!cpu_we) begin
              cpu_rdata <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: self-checking bench for dbus_arbiter. A behavioural BRAM
// sits on the memory port; expectations come from a shadow word array, a
// shadow LED value and a shadow "last load result", updated per completed
// transaction. Honours UART_LOADER_EN the same way the design does.
module tb_dbus_arbiter;

  localparam int          MEM_AW = 14;
  localparam logic [31:0] LED_A  = 32'hFFFFFC60;
  localparam logic [31:0] SW_A   = 32'hFFFFFC70;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              ld_req;
  logic [MEM_AW-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_ack;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [15:0]       led_out;
  logic [15:0]       sw_in;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] bram [0:(1<<MEM_AW)-1];
  logic [31:0] ref_mem [0:15];
  logic [15:0] ref_led;
  logic [31:0] ref_rdata;
  logic [31:0] unmapped_tbl [0:3] = '{32'hFFFFFC80, 32'hFFFFFC00, 32'hFFFFFFFC, 32'hFFFFFC64};

  dbus_arbiter #(
    .IO_PREFIX(22'h3FFFFF),
    .LED_ADDR (LED_A),
    .SW_ADDR  (SW_A),
    .MEM_AW   (MEM_AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_ack   (ld_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .led_out  (led_out),
    .sw_in    (sw_in)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-cycle-latency BRAM, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= bram[mem_addr];
    end
  end

  // One comparison: counts it, and on a mismatch reports tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive every requester input in one go.
  task automatic applyStimulus(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                               input logic [31:0] c_wdata, input logic l_req,
                               input logic [MEM_AW-1:0] l_addr, input logic [31:0] l_wdata);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    ld_req    = l_req;
    ld_addr   = l_addr;
    ld_wdata  = l_wdata;
  endtask

  // One CPU access from an idle bus: snapshots the BRAM port in the
  // acceptance cycle and returns the cycles to cpu_ready (0 = timed out).
  task automatic cpuTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic a_en,
                        output logic a_we, output logic [MEM_AW-1:0] a_addr,
                        output logic [31:0] a_wdata);
    @(negedge clk);
    applyStimulus(1'b1, we, addr, wdata, 1'b0, '0, '0);
    #1;
    a_en    = mem_en;
    a_we    = mem_we;
    a_addr  = mem_addr;
    a_wdata = mem_wdata;
    lat     = 0;
    rd      = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = c;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  // One loader write from an idle bus, same bookkeeping as cpuTxn.
  task automatic ldTxn(input logic [MEM_AW-1:0] addr, input logic [31:0] wdata, output int lat,
                       output logic a_en, output logic a_we, output logic [MEM_AW-1:0] a_addr);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, addr, wdata);
    #1;
    a_en   = mem_en;
    a_we   = mem_we;
    a_addr = mem_addr;
    lat    = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ld_ack) begin
        lat = c;
        break;
      end
    end
    ld_req = 1'b0;
  endtask

  // Directed steps first, then a randomized run against the shadow model.
  initial begin
    int                lat;
    logic [31:0]       rd;
    logic              a_en;
    logic              a_we;
    logic [MEM_AW-1:0] a_addr;
    logic [31:0]       a_wdata;
    int                ready_seen;
    int                coincide;
    int                events[$];
    int                op;
    logic [3:0]        idx;
    logic [31:0]       maddr;
    logic [31:0]       wd;
    logic [31:0]       exp_ev;

    for (int i = 0; i < (1 << MEM_AW); i++) bram[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    mem_rdata = '0;
    sw_in     = '0;
    rst       = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
    checkOutput("rst_ld_ack", {31'b0, ld_ack}, 32'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_led_out", {16'h0, led_out}, 32'h0);
    checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    ref_led   = '0;
    ref_rdata = '0;

    // Memory store then load of the same word.
    cpuTxn(1'b1, 32'h0000_0010, 32'hDEADBEEF, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("st_mem_we", {31'b0, a_we}, 32'h1);
    checkOutput("st_mem_addr", 32'(a_addr), 32'h4);
    checkOutput("st_mem_wdata", a_wdata, 32'hDEADBEEF);
    checkOutput("st_latency", lat, 1);
    ref_mem[4] = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("st_ready_pulse", {31'b0, cpu_ready}, 32'h0);
    cpuTxn(1'b0, 32'h0000_0010, 32'h0, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("ld_latency", lat, 2);
    checkOutput("ld_rdata", rd, 32'hDEADBEEF);
    ref_rdata = 32'hDEADBEEF;

    // LED store, switch read, unmapped read, byte-offset alias of LED.
    cpuTxn(1'b1, LED_A, 32'h1234_A5A5, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("led_latency", lat, 1);
    checkOutput("led_value", {16'h0, led_out}, 32'h0000_A5A5);
    checkOutput("led_no_mem", {31'b0, a_en}, 32'h0);
    sw_in = 16'h00F3;
    cpuTxn(1'b0, SW_A, 32'h0, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("sw_latency", lat, 1);
    checkOutput("sw_rdata", rd, 32'h0000_00F3);
    cpuTxn(1'b0, 32'hFFFFFC80, 32'h0, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("unm_latency", lat, 1);
    checkOutput("unm_rdata", rd, 32'h0);
    cpuTxn(1'b1, LED_A | 32'h2, 32'h0000_5A5A, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("led_alias", {16'h0, led_out}, 32'h0000_5A5A);

    // Reset during RD_WAIT: abandoned, no ready, registers cleared.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, '0, 1'b0, '0, '0);
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ready_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ready) ready_seen++;
    end
    checkOutput("rstmid_no_ready", ready_seen, 0);
    checkOutput("rstmid_led", {16'h0, led_out}, 32'h0);
    checkOutput("rstmid_rdata", cpu_rdata, 32'h0);
    cpuTxn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, lat, rd, a_en, a_we, a_addr, a_wdata);
    checkOutput("rstmid_idle", lat, 1);
    ref_mem[8] = 32'h0BAD_F00D;

    // Both requesters held from reset: grants alternate starting with
    // the loader; a CPU-only build sees only CPU completions.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 1'b1, 14'd40, 32'hBEEF_0002);
    @(negedge clk);
    rst = 1'b0;
    coincide = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (cpu_ready && ld_ack) coincide++;
      else if (ld_ack) events.push_back(1);
      else if (cpu_ready) events.push_back(0);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("tie_coincide", coincide, 0);
    checkOutput("tie_enough", {31'b0, events.size() >= 6}, 32'h1);
    for (int i = 0; i < 6; i++) begin
`ifdef UART_LOADER_EN
      exp_ev = (i % 2 == 0) ? 32'h1 : 32'h0;
`else
      exp_ev = 32'h0;
`endif
      if (i < events.size()) checkOutput($sformatf("tie_grant_%0d", i), events[i], exp_ev);
    end
    ref_led   = '0;
    ref_rdata = '0;

`ifndef UART_LOADER_EN
    // Loader requests are ignored entirely in a CPU-only build.
    ldTxn(14'd3, 32'h5555_AAAA, lat, a_en, a_we, a_addr);
    checkOutput("noload_ack", lat, 0);
    checkOutput("noload_mem_en", {31'b0, a_en}, 32'h0);
`endif

    // Randomized single-requester traffic against the shadow model.
    for (int n = 0; n < 60; n++) begin
`ifdef UART_LOADER_EN
      op = int'($urandom_range(0, 6));
`else
      op = int'($urandom_range(0, 5));
`endif
      idx   = 4'($urandom_range(0, 15));
      maddr = (32'($urandom_range(0, 7)) << 16) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      wd    = $urandom;
      case (op)
        0: begin
          cpuTxn(1'b1, maddr, wd, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_st_lat", lat, 1);
          checkOutput("rnd_st_addr", 32'(a_addr), 32'(idx));
          checkOutput("rnd_st_we", {31'b0, a_we}, 32'h1);
          checkOutput("rnd_st_hold", rd, ref_rdata);
          ref_mem[idx] = wd;
        end
        1: begin
          cpuTxn(1'b0, maddr, wd, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_ld_lat", lat, 2);
          checkOutput("rnd_ld_we", {31'b0, a_we}, 32'h0);
          checkOutput("rnd_ld_data", rd, ref_mem[idx]);
          ref_rdata = ref_mem[idx];
        end
        2: begin
          cpuTxn(1'b1, LED_A, wd, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_led_lat", lat, 1);
          checkOutput("rnd_led_val", {16'h0, led_out}, {16'h0, wd[15:0]});
          checkOutput("rnd_led_nomem", {31'b0, a_en}, 32'h0);
          ref_led = wd[15:0];
        end
        3: begin
          sw_in = wd[31:16];
          cpuTxn(1'b0, SW_A, 32'h0, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_sw_lat", lat, 1);
          checkOutput("rnd_sw_data", rd, {16'h0, wd[31:16]});
          ref_rdata = {16'h0, wd[31:16]};
        end
        4: begin
          cpuTxn(1'b0, unmapped_tbl[idx[1:0]], 32'h0, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_unm_ld_lat", lat, 1);
          checkOutput("rnd_unm_ld_data", rd, 32'h0);
          ref_rdata = 32'h0;
        end
        5: begin
          cpuTxn(1'b1, unmapped_tbl[idx[1:0]], wd, lat, rd, a_en, a_we, a_addr, a_wdata);
          checkOutput("rnd_unm_st_lat", lat, 1);
          checkOutput("rnd_unm_st_led", {16'h0, led_out}, {16'h0, ref_led});
          checkOutput("rnd_unm_st_nomem", {31'b0, a_en}, 32'h0);
          checkOutput("rnd_unm_st_hold", rd, ref_rdata);
        end
        default: begin
          ldTxn(MEM_AW'(idx), wd, lat, a_en, a_we, a_addr);
          checkOutput("rnd_ldr_lat", lat, 1);
          checkOutput("rnd_ldr_we", {31'b0, a_we}, 32'h1);
          checkOutput("rnd_ldr_addr", 32'(a_addr), 32'(idx));
          ref_mem[idx] = wd;
        end
      endcase
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
